// File: rtl/i2s_playout_controller.sv
// Playout sequencer for the I2S MSB transmitter reading the circular channel_buffer.
// Primes on producer advances, requests transmitter resync, and polices playout lag.
module i2s_playout_controller #(
  parameter int CIRC_BUF_BITS = 3,
  parameter int ADDR_BITS     = 11,
  parameter int TARGET_LAG    = 4,
  parameter int LAG_TOL       = 1,
  parameter int LOCK_FRAMES   = 2,
  parameter int STALL_TIMEOUT = 4096
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     enable_i,
  input  logic [CIRC_BUF_BITS-1:0] wr_frame_idx_i,
  input  logic [ADDR_BITS-1:0]     ram_read_addr_i,
  input  logic                     i2s_running_i,
  output logic                     resync_req_o,
  output logic [CIRC_BUF_BITS-1:0] last_good_frame_idx_o,
  output logic                     locked_o,
  output logic                     underrun_o,
  output logic                     overrun_o,
  output logic [7:0]               resync_count_o
);

  // state  | meaning
  // IDLE   | playout disabled or dropped after a producer stall
  // PRIME  | counting producer advances before the first resync
  // RESYNC | resync_req_o held until a frame boundary with transmitter running
  // RUN    | locked; lag checked on every read-side frame boundary

  localparam int FRAME_BITS = ADDR_BITS - CIRC_BUF_BITS;
  localparam int STALL_W    = $clog2(STALL_TIMEOUT);
  localparam int ADV_W      = $clog2(LOCK_FRAMES + 1);

  localparam logic [STALL_W-1:0]       STALL_RELOAD = STALL_W'(STALL_TIMEOUT - 1);
  localparam logic [ADV_W-1:0]         ADV_LAST     = ADV_W'(LOCK_FRAMES - 1);
  localparam logic [CIRC_BUF_BITS-1:0] LAG_MIN      = CIRC_BUF_BITS'(TARGET_LAG - LAG_TOL);
  localparam logic [CIRC_BUF_BITS-1:0] LAG_MAX      = CIRC_BUF_BITS'(TARGET_LAG + LAG_TOL);

  typedef enum logic [1:0] {IDLE, PRIME, RESYNC, RUN} state_t;

  state_t                   state;
  logic [CIRC_BUF_BITS-1:0] wr_idx_q;
  logic [ADV_W-1:0]         adv_cnt;
  logic [STALL_W-1:0]       stall_cnt;
  logic                     seen_adv;

  logic                     advance;
  logic                     boundary;
  logic                     stall_expired;
  logic [CIRC_BUF_BITS-1:0] rd_frame;
  logic [CIRC_BUF_BITS-1:0] lag;

  assign advance       = (wr_frame_idx_i != wr_idx_q);
  assign rd_frame      = ram_read_addr_i[ADDR_BITS-1 -: CIRC_BUF_BITS];
  assign boundary      = &ram_read_addr_i[FRAME_BITS-1:0];
  // Uses the live producer index so a same-cycle advance is already counted.
  assign lag           = wr_frame_idx_i - rd_frame;
  assign stall_expired = (state != IDLE) && !advance && (stall_cnt == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state                 <= IDLE;
      wr_idx_q              <= '0;
      adv_cnt               <= '0;
      stall_cnt             <= STALL_RELOAD;
      seen_adv              <= 1'b0;
      resync_req_o          <= 1'b0;
      last_good_frame_idx_o <= '0;
      locked_o              <= 1'b0;
      underrun_o            <= 1'b0;
      overrun_o             <= 1'b0;
      resync_count_o        <= '0;
    end else begin
      wr_idx_q   <= wr_frame_idx_i;
      underrun_o <= 1'b0;
      overrun_o  <= 1'b0;

      if (state != IDLE) begin
        last_good_frame_idx_o <= wr_frame_idx_i;
      end

      // Down-counter reloads on each advance; zero with no advance is the timeout.
      if (state == IDLE || advance) begin
        stall_cnt <= STALL_RELOAD;
      end else if (stall_cnt != '0) begin
        stall_cnt <= stall_cnt - 1'b1;
      end

      if (!enable_i) begin
        state        <= IDLE;
        resync_req_o <= 1'b0;
        locked_o     <= 1'b0;
      end else if (stall_expired) begin
        underrun_o   <= 1'b1;
        state        <= IDLE;
        resync_req_o <= 1'b0;
        locked_o     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state   <= PRIME;
            adv_cnt <= '0;
          end
          PRIME: begin
            if (advance) begin
              if (adv_cnt == ADV_LAST) begin
                state        <= RESYNC;
                resync_req_o <= 1'b1;
                seen_adv     <= 1'b0;
              end else begin
                adv_cnt <= adv_cnt + 1'b1;
              end
            end
          end
          RESYNC: begin
            if (advance) begin
              seen_adv <= 1'b1;
            end
            if (boundary && i2s_running_i && (seen_adv || advance)) begin
              state        <= RUN;
              resync_req_o <= 1'b0;
              locked_o     <= 1'b1;
            end
          end
          RUN: begin
            if (boundary && (lag < LAG_MIN || lag > LAG_MAX)) begin
              underrun_o   <= (lag < LAG_MIN);
              overrun_o    <= (lag > LAG_MAX);
              state        <= RESYNC;
              resync_req_o <= 1'b1;
              locked_o     <= 1'b0;
              seen_adv     <= 1'b0;
              if (resync_count_o != 8'hFF) begin
                resync_count_o <= resync_count_o + 1'b1;
              end
            end
          end
          default: begin
            state        <= IDLE;
            resync_req_o <= 1'b0;
            locked_o     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2s_playout_controller.sv
// Bench for i2s_playout_controller: directed vector table, hand-written corner
// sequences and randomized stimulus, all checked against a behavioural model.
module tb_i2s_playout_controller;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        enable_i = 1'b0;
  logic [2:0]  wr_frame_idx_i = '0;
  logic [10:0] ram_read_addr_i = '0;
  logic        i2s_running_i = 1'b0;
  logic        resync_req_o;
  logic [2:0]  last_good_frame_idx_o;
  logic        locked_o;
  logic        underrun_o;
  logic        overrun_o;
  logic [7:0]  resync_count_o;

  i2s_playout_controller dut (
    .clk_i                 (clk_i),
    .rst_ni                (rst_ni),
    .enable_i              (enable_i),
    .wr_frame_idx_i        (wr_frame_idx_i),
    .ram_read_addr_i       (ram_read_addr_i),
    .i2s_running_i         (i2s_running_i),
    .resync_req_o          (resync_req_o),
    .last_good_frame_idx_o (last_good_frame_idx_o),
    .locked_o              (locked_o),
    .underrun_o            (underrun_o),
    .overrun_o             (overrun_o),
    .resync_count_o        (resync_count_o)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: modes, plain integer counters and modular lag arithmetic.
  typedef enum int {M_OFF, M_PRIMING, M_SYNCING, M_LOCKED} mode_t;
  mode_t m_mode;
  int    m_advs, m_quiet, m_prev, m_lgf, m_cnt;
  bit    m_seen, m_req, m_lock, m_under, m_over;

  task automatic model_reset();
    m_mode = M_OFF; m_advs = 0; m_quiet = 0; m_prev = 0; m_lgf = 0; m_cnt = 0;
    m_seen = 0; m_req = 0; m_lock = 0; m_under = 0; m_over = 0;
  endtask

  task automatic model_step();
    int wr, rd, lag;
    bit adv, bnd;
    wr  = int'(wr_frame_idx_i);
    rd  = int'(ram_read_addr_i[10:8]);
    bnd = (ram_read_addr_i[7:0] == 8'hFF);
    adv = (wr != m_prev);
    m_prev = wr;
    lag = (wr - rd + 8) % 8;
    m_under = 0;
    m_over  = 0;
    if (m_mode != M_OFF) m_lgf = wr;
    if (m_mode == M_OFF || adv) m_quiet = 0;
    else m_quiet++;
    if (!enable_i) m_mode = M_OFF;
    else if (m_mode != M_OFF && m_quiet >= 4096) begin
      m_under = 1;
      m_mode  = M_OFF;
    end else begin
      case (m_mode)
        M_OFF: begin m_mode = M_PRIMING; m_advs = 0; end
        M_PRIMING: begin
          if (adv) m_advs++;
          if (m_advs >= 2) begin m_mode = M_SYNCING; m_seen = 0; end
        end
        M_SYNCING: begin
          if (adv) m_seen = 1;
          if (bnd && i2s_running_i && m_seen) m_mode = M_LOCKED;
        end
        M_LOCKED: begin
          if (bnd && (lag < 3 || lag > 5)) begin
            if (lag < 3) m_under = 1;
            else m_over = 1;
            m_mode = M_SYNCING;
            m_seen = 0;
            if (m_cnt < 255) m_cnt++;
          end
        end
        default: m_mode = M_OFF;
      endcase
    end
    m_req  = (m_mode == M_SYNCING);
    m_lock = (m_mode == M_LOCKED);
  endtask

  function automatic logic [15:0] dut_pack();
    return {resync_req_o, locked_o, underrun_o, overrun_o, 1'b0, last_good_frame_idx_o, resync_count_o};
  endfunction

  function automatic logic [15:0] exp_pack(bit req, bit lock, bit un, bit ov, int lgf, int cnt);
    return {req, lock, un, ov, 1'b0, 3'(lgf), 8'(cnt)};
  endfunction

  task automatic compare(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic drive(input bit en, input int w, input logic [10:0] addr, input bit run);
    enable_i        = en;
    wr_frame_idx_i  = 3'(w);
    ram_read_addr_i = addr;
    i2s_running_i   = run;
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_step();
    @(negedge clk_i);
    compare("model", 32'(dut_pack()), 32'(exp_pack(m_req, m_lock, m_under, m_over, m_lgf, m_cnt)));
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    drive(0, 0, '0, 0);
    repeat (2) @(negedge clk_i);
    model_reset();
    rst_ni = 1'b1;
  endtask

  // Walks IDLE -> PRIME -> RESYNC -> RUN with the producer starting at w.
  task automatic lock_up(inout int w);
    drive(1, w, '0, 1); tick();
    w++; drive(1, w, '0, 1); tick();
    w++; drive(1, w, '0, 1); tick();
    w++; drive(1, w, {3'(w - 4), 8'hFF}, 1); tick();
    compare("lock_up_locked", 32'(locked_o), 32'd1);
  endtask

  typedef struct {
    bit   en;
    int   wr;
    logic [10:0] addr;
    bit   run;
    bit   req, lock, un, ov;
    int   lgf, cnt;
  } vec_t;

  vec_t tbl[22];

  initial begin
    int w, n;

    tbl[0]  = '{1, 0, 11'h000, 1, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 11'h000, 1, 0, 0, 0, 0, 1, 0};
    tbl[2]  = '{1, 2, 11'h000, 1, 1, 0, 0, 0, 2, 0};
    tbl[3]  = '{1, 2, 11'h2FF, 1, 1, 0, 0, 0, 2, 0};
    tbl[4]  = '{1, 3, 11'h000, 1, 1, 0, 0, 0, 3, 0};
    tbl[5]  = '{1, 3, 11'h0FF, 0, 1, 0, 0, 0, 3, 0};
    tbl[6]  = '{1, 3, 11'h0FF, 1, 0, 1, 0, 0, 3, 0};
    tbl[7]  = '{1, 5, 11'h1FF, 1, 0, 1, 0, 0, 5, 0};
    tbl[8]  = '{1, 5, 11'h100, 1, 0, 1, 0, 0, 5, 0};
    tbl[9]  = '{1, 1, 11'h7FF, 1, 1, 0, 1, 0, 1, 1};
    tbl[10] = '{1, 1, 11'h000, 1, 1, 0, 0, 0, 1, 1};
    tbl[11] = '{1, 2, 11'h0FF, 1, 0, 1, 0, 0, 2, 1};
    tbl[12] = '{1, 2, 11'h4FF, 1, 1, 0, 0, 1, 2, 2};
    tbl[13] = '{1, 3, 11'h5FF, 1, 0, 1, 0, 0, 3, 2};
    tbl[14] = '{1, 3, 11'h3FF, 1, 1, 0, 1, 0, 3, 3};
    tbl[15] = '{1, 4, 11'h6FF, 1, 0, 1, 0, 0, 4, 3};
    tbl[16] = '{1, 4, 11'h1FF, 1, 0, 1, 0, 0, 4, 3};
    tbl[17] = '{1, 6, 11'h1FF, 1, 0, 1, 0, 0, 6, 3};
    tbl[18] = '{1, 6, 11'h2FE, 1, 0, 1, 0, 0, 6, 3};
    tbl[19] = '{1, 7, 11'h1FF, 1, 1, 0, 0, 1, 7, 4};
    tbl[20] = '{0, 7, 11'h000, 1, 0, 0, 0, 0, 7, 4};
    tbl[21] = '{0, 7, 11'h000, 1, 0, 0, 0, 0, 7, 4};

    do_reset();
    compare("reset_outputs", 32'(dut_pack()), 32'd0);

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].en, tbl[i].wr, tbl[i].addr, tbl[i].run);
      tick();
      compare($sformatf("table_row_%0d", i), 32'(dut_pack()),
              32'(exp_pack(tbl[i].req, tbl[i].lock, tbl[i].un, tbl[i].ov, tbl[i].lgf, tbl[i].cnt)));
    end

    // Producer frozen while locked: underrun exactly 4096 cycles after the last advance.
    w = 7;
    lock_up(w);
    drive(1, w, {3'(w - 4), 8'h00}, 1);
    n = 0;
    do begin
      tick();
      n++;
    end while (!underrun_o && n < 5000);
    compare("stall_cycles", 32'(n), 32'd4096);
    compare("stall_locked", 32'(locked_o), 32'd0);
    compare("stall_req", 32'(resync_req_o), 32'd0);
    compare("stall_count", 32'(resync_count_o), 32'd4);

    // enable_i drop on the very cycle the stall timer would fire in RESYNC.
    drive(1, w, '0, 1); tick();
    w++; drive(1, w, '0, 1); tick();
    w++; drive(1, w, '0, 1); tick();
    compare("prime_to_resync", 32'(resync_req_o), 32'd1);
    repeat (4095) tick();
    compare("resync_before_drop", 32'(resync_req_o), 32'd1);
    drive(0, w, '0, 1); tick();
    compare("drop_no_underrun", 32'(underrun_o), 32'd0);
    compare("drop_req", 32'(resync_req_o), 32'd0);

    // Repeated lag faults saturate the resync counter.
    lock_up(w);
    for (int k = 0; k < 260; k++) begin
      drive(1, w, {3'(w), 8'hFF}, 1); tick();
      w++; drive(1, w, {3'(w - 4), 8'hFF}, 1); tick();
    end
    compare("resync_count_saturated", 32'(resync_count_o), 32'hFF);
    drive(1, w, {3'(w), 8'hFF}, 1); tick();
    compare("sat_fault_req", 32'(resync_req_o), 32'd1);
    compare("sat_fault_count", 32'(resync_count_o), 32'hFF);

    // Asynchronous reset mid-RESYNC, sampled between clock edges.
    #2 rst_ni = 1'b0;
    #1 compare("async_reset", 32'(dut_pack()), 32'd0);
    do_reset();

    w = 0;
    for (int c = 0; c < 8000; c++) begin
      int rd;
      logic [7:0] lo;
      if ($urandom_range(0, 15) == 0) w++;
      if ($urandom_range(0, 9) < 7) rd = w - $urandom_range(3, 5);
      else rd = $urandom_range(0, 7);
      lo = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
      drive($urandom_range(0, 299) != 0, w, {3'(rd), lo}, $urandom_range(0, 9) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
